// File: rtl/bf_data_port.sv
// bf_data_port: data SRAM plus TX/RX byte FIFOs serving the core's one-cycle data strobes.
module bf_data_port #(
  parameter int AWIDTH  = 12,
  parameter int DWIDTH  = 16,
  parameter int TXDEPTH = 16,
  parameter int RXDEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_rst,
  input  logic [AWIDTH-1:0] dp_adr,
  input  logic [DWIDTH-1:0] data_out,
  input  logic              data_w_req,
  input  logic              data_w_sel,
  input  logic              data_r_req,
  input  logic              data_r_sel,
  output logic [DWIDTH-1:0] data_in,
  output logic              data_den,
  output logic              data_w_wait,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              clr_flags,
  output logic              tx_overflow,
  output logic              rx_underrun
);
  localparam int TAW = $clog2(TXDEPTH);
  localparam int RAW = $clog2(RXDEPTH);
  logic [DWIDTH-1:0] mem [2**AWIDTH];
  logic [7:0]        tx_mem [TXDEPTH];
  logic [7:0]        rx_mem [RXDEPTH];
  logic [TAW-1:0]    tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [TAW:0]      tx_cnt_q, tx_cnt_d;
  logic [RAW-1:0]    rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [RAW:0]      rx_cnt_q, rx_cnt_d;
  logic [DWIDTH-1:0] data_in_q, data_in_d, sram_rd;
  logic              den_q, den_d, ovf_q, ovf_d, und_q, und_d;
  logic              sram_w, sram_r, tx_req, rx_req;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  assign sram_w   = data_w_req & ~data_w_sel;
  assign tx_req   = data_w_req & data_w_sel;
  assign sram_r   = data_r_req & ~data_r_sel;
  assign rx_req   = data_r_req & data_r_sel;
  assign tx_full  = tx_cnt_q == (TAW+1)'(TXDEPTH);
  assign tx_empty = tx_cnt_q == '0;
  assign rx_full  = rx_cnt_q == (RAW+1)'(RXDEPTH);
  assign rx_empty = rx_cnt_q == '0;
  // A full TX FIFO still takes a push when its head leaves in the same cycle.
  assign tx_pop   = ~tx_empty & tx_ready;
  assign tx_push  = tx_req & (~tx_full | tx_pop);
  assign rx_push  = rx_valid & ~rx_full;
  assign rx_pop   = rx_req & ~rx_empty;
  // Read and write share dp_adr, so a concurrent write always hits the read word.
  assign sram_rd  = sram_w ? data_out : mem[dp_adr];
  assign data_in     = data_in_q;
  assign data_den    = den_q;
  assign data_w_wait = tx_full;
  assign tx_valid    = ~tx_empty;
  assign tx_data     = tx_empty ? 8'h00 : tx_mem[tx_rp_q];
  assign rx_ready    = ~rx_full;
  assign tx_overflow = ovf_q;
  assign rx_underrun = und_q;
  always_comb begin
    tx_wp_d   = s_rst ? '0 : tx_wp_q + TAW'(tx_push);
    tx_rp_d   = s_rst ? '0 : tx_rp_q + TAW'(tx_pop);
    tx_cnt_d  = s_rst ? '0 : tx_cnt_q + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
    rx_wp_d   = s_rst ? '0 : rx_wp_q + RAW'(rx_push);
    rx_rp_d   = s_rst ? '0 : rx_rp_q + RAW'(rx_pop);
    rx_cnt_d  = s_rst ? '0 : rx_cnt_q + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
    ovf_d     = (s_rst | clr_flags) ? 1'b0 : ovf_q | (tx_req & ~tx_push);
    und_d     = (s_rst | clr_flags) ? 1'b0 : und_q | (rx_req & rx_empty);
    den_d     = ~s_rst & (sram_r | rx_pop);
    data_in_d = s_rst  ? '0 :
                sram_r ? sram_rd :
                rx_req ? (rx_pop ? DWIDTH'(rx_mem[rx_rp_q]) : '0) :
                data_in_q;
  end
  always_ff @(posedge clk) begin
    if (sram_w) mem[dp_adr] <= data_out;
    if (tx_push) tx_mem[tx_wp_q] <= data_out[7:0];
    if (rx_push) rx_mem[rx_wp_q] <= rx_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_cnt_q  <= '0;
      data_in_q <= '0;
      den_q     <= 1'b0;
      ovf_q     <= 1'b0;
      und_q     <= 1'b0;
    end else begin
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      rx_cnt_q  <= rx_cnt_d;
      data_in_q <= data_in_d;
      den_q     <= den_d;
      ovf_q     <= ovf_d;
      und_q     <= und_d;
    end
  end
endmodule

// File: tb/tb_bf_data_port.sv
// tb_bf_data_port: directed bench with a read-result scoreboard and a TX byte model.
module tb_bf_data_port;
  logic        clk, rst, s_rst;
  logic [11:0] dp_adr;
  logic [15:0] data_out, data_in;
  logic        data_w_req, data_w_sel, data_r_req, data_r_sel;
  logic        data_den, data_w_wait;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic        clr_flags, tx_overflow, rx_underrun;
  int          total = 0;
  int          bad = 0;
  logic [16:0] exp_q [$];
  logic [7:0]  txq [$];
  bf_data_port dut (
    .clk(clk), .rst(rst), .s_rst(s_rst), .dp_adr(dp_adr), .data_out(data_out),
    .data_w_req(data_w_req), .data_w_sel(data_w_sel), .data_r_req(data_r_req),
    .data_r_sel(data_r_sel), .data_in(data_in), .data_den(data_den),
    .data_w_wait(data_w_wait), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .clr_flags(clr_flags), .tx_overflow(tx_overflow), .rx_underrun(rx_underrun)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #200000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic w, input logic ws, input logic r, input logic rs, input logic [15:0] d);
    data_w_req = w;
    data_w_sel = ws;
    data_r_req = r;
    data_r_sel = rs;
    data_out   = d;
  endtask
  task automatic rd_check(input string tag);
    logic [16:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_noexp"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {data_den, data_in}, e);
    end
  endtask
  task automatic rx_pop(input logic [16:0] e);
    req(1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
    exp_q.push_back(e);
    tick;
    req(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    rd_check("rx_pop");
  endtask
  task automatic tx_fill(input logic [7:0] base, input int n);
    tx_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      req(1'b1, 1'b1, 1'b0, 1'b0, {8'h00, base + 8'(i)});
      if (txq.size() < 16) txq.push_back(base + 8'(i));
      tick;
      if (i == 0) chk("tx_valid_n1", tx_valid, 1);
      if (i == 15) begin
        chk("w_wait_full", data_w_wait, 1);
        chk("ovf_not_yet", tx_overflow, 0);
      end
    end
    req(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask
  task automatic drain(input int n);
    tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk("tx_valid", tx_valid, 1);
      chk("tx_head", tx_data, txq.pop_front());
      tick;
    end
    tx_ready = 1'b0;
  endtask
  initial begin
    rst = 1'b1; s_rst = 1'b0; dp_adr = 12'h005; clr_flags = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    req(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    tick;
    chk("rst_data_in", data_in, 0);
    chk("rst_den", data_den, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_ovf", tx_overflow, 0);
    chk("rst_und", rx_underrun, 0);
    chk("rst_w_wait", data_w_wait, 0);
    chk("rst_tx_data", tx_data, 0);
    rst = 1'b0;
    tick;
    // SRAM write then read
    req(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234);
    tick;
    req(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    exp_q.push_back({1'b1, 16'h1234});
    tick;
    req(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    rd_check("sram_rd");
    tick;
    chk("idle_hold", {data_den, data_in}, {1'b0, 16'h1234});
    req(1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF);
    exp_q.push_back({1'b1, 16'hBEEF});
    tick;
    req(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    rd_check("write_first");
    // TX overflow
    tx_fill(8'h41, 17);
    chk("ovf_set", tx_overflow, 1);
    chk("tx_count_q", txq.size(), 16);
    drain(16);
    chk("tx_empty_valid", tx_valid, 0);
    chk("tx_empty_data", tx_data, 0);
    chk("w_wait_clear", data_w_wait, 0);
    clr_flags = 1'b1;
    tick;
    clr_flags = 1'b0;
    chk("ovf_cleared", tx_overflow, 0);
    // TX full with simultaneous pop and push
    tx_fill(8'h60, 16);
    tx_ready = 1'b1;
    req(1'b1, 1'b1, 1'b0, 1'b0, 16'h007A);
    chk("full_head", tx_data, txq.pop_front());
    txq.push_back(8'h7A);
    tick;
    req(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    tx_ready = 1'b0;
    chk("full_pp_wait", data_w_wait, 1);
    chk("full_pp_ovf", tx_overflow, 0);
    drain(16);
    chk("full_pp_empty", tx_valid, 0);
    // RX path
    rx_valid = 1'b1; rx_data = 8'h30;
    tick;
    rx_data = 8'h31;
    tick;
    rx_valid = 1'b0;
    rx_pop({1'b1, 16'h0030});
    rx_pop({1'b1, 16'h0031});
    rx_pop({1'b0, 16'h0000});
    chk("und_set", rx_underrun, 1);
    clr_flags = 1'b1;
    tick;
    clr_flags = 1'b0;
    chk("und_cleared", rx_underrun, 0);
    // RX full
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'h80 + 8'(i);
      tick;
    end
    chk("rx_full", rx_ready, 0);
    rx_data = 8'hFF;
    tick;
    tick;
    chk("rx_full_hold", rx_ready, 0);
    req(1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
    exp_q.push_back({1'b1, 16'h0080});
    tick;
    req(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    rx_valid = 1'b0;
    rd_check("rx_full_pop");
    chk("rx_ready_back", rx_ready, 1);
    for (int i = 1; i < 16; i++) rx_pop({1'b1, 8'h00, 8'h80 + 8'(i)});
    clr_flags = 1'b1;
    rx_pop({1'b0, 16'h0000});
    clr_flags = 1'b0;
    chk("clear_wins", rx_underrun, 0);
    // s_rst with half-full FIFOs and both flags set
    rx_pop({1'b0, 16'h0000});
    chk("und_set2", rx_underrun, 1);
    tx_fill(8'hA0, 17);
    chk("ovf_set2", tx_overflow, 1);
    drain(8);
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'hC0 + 8'(i);
      tick;
    end
    rx_valid = 1'b0;
    chk("half_tx_valid", tx_valid, 1);
    s_rst = 1'b1;
    tick;
    s_rst = 1'b0;
    txq.delete();
    chk("srst_tx_valid", tx_valid, 0);
    chk("srst_tx_data", tx_data, 0);
    chk("srst_w_wait", data_w_wait, 0);
    chk("srst_rx_ready", rx_ready, 1);
    chk("srst_ovf", tx_overflow, 0);
    chk("srst_und", rx_underrun, 0);
    chk("srst_data", {data_den, data_in}, 17'h0);
    rx_pop({1'b0, 16'h0000});
    req(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    exp_q.push_back({1'b1, 16'hBEEF});
    tick;
    req(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    rd_check("sram_kept");
    // async rst mid-read
    req(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    @(posedge clk);
    #1;
    chk("pre_rst_den", data_den, 1);
    rst = 1'b1;
    #1;
    chk("arst_den", data_den, 0);
    chk("arst_data", data_in, 0);
    req(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    tick;
    rst = 1'b0;
    tick;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
